execute_stage: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline, directly downstream of the ALU decoder.
- Consumes the 4-bit ALU control code together with ID/EX operands.
- Applies forwarding, performs the ALU operation and resolves branches and jumps.
- Registers the results into the EX/MEM pipeline register, with stall and flush.

---
 rtl/execute_stage_if.sv | 61 ++++++
 rtl/execute_stage.sv | 151 +++++++++++++++
 tb/tb_execute_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// Purpose : bundles the ID/EX inputs, EX-stage redirect outputs and EX/MEM register outputs
//           of the RV32I execute stage into one interface.
// Ports   : master = pipeline control / upstream side (drives ID/EX, observes results),
//           slave  = execute_stage (consumes ID/EX, drives redirect and EX/MEM fields).
interface execute_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) ();
  // hazard-unit controls for the EX/MEM register
  logic                  stall_m;
  logic                  flush_m;
  // ID/EX register contents
  logic                  valid_e;
  logic [XLEN-1:0]       rd1_e;
  logic [XLEN-1:0]       rd2_e;
  logic [XLEN-1:0]       imm_ext_e;
  logic [XLEN-1:0]       pc_e;
  logic [XLEN-1:0]       pc_plus4_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic [3:0]            alu_control_e;
  logic                  alu_src_e;
  logic [2:0]            funct3_e;
  logic                  branch_e;
  logic                  jump_e;
  logic                  jalr_e;
  logic                  reg_write_e;
  logic                  mem_write_e;
  logic [1:0]            result_src_e;
  logic [1:0]            forward_a_e;
  logic [1:0]            forward_b_e;
  // writeback-stage result used for forwarding
  logic [XLEN-1:0]       result_w;
  // fetch redirect, combinational
  logic                  pc_src_e;
  logic [XLEN-1:0]       pc_target_e;
  // EX/MEM register outputs
  logic [XLEN-1:0]       alu_result_m;
  logic [XLEN-1:0]       write_data_m;
  logic [REG_ADDR_W-1:0] rd_m;
  logic [XLEN-1:0]       pc_plus4_m;
  logic                  reg_write_m;
  logic                  mem_write_m;
  logic [1:0]            result_src_m;
  logic                  valid_m;

  modport master (
    output stall_m, flush_m, valid_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rd_e,
           alu_control_e, alu_src_e, funct3_e, branch_e, jump_e, jalr_e, reg_write_e,
           mem_write_e, result_src_e, forward_a_e, forward_b_e, result_w,
    input  pc_src_e, pc_target_e, alu_result_m, write_data_m, rd_m, pc_plus4_m,
           reg_write_m, mem_write_m, result_src_m, valid_m
  );

  modport slave (
    input  stall_m, flush_m, valid_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rd_e,
           alu_control_e, alu_src_e, funct3_e, branch_e, jump_e, jalr_e, reg_write_e,
           mem_write_e, result_src_e, forward_a_e, forward_b_e, result_w,
    output pc_src_e, pc_target_e, alu_result_m, write_data_m, rd_m, pc_plus4_m,
           reg_write_m, mem_write_m, result_src_m, valid_m
  );
endinterface

// File: rtl/execute_stage.sv
// Purpose     : RV32I execute stage - operand forwarding, ALU, branch/jump resolution, EX/MEM register.
// Latency     : EX inputs to _m outputs one cycle; pc_src_e / pc_target_e are combinational (zero cycles).
// Backpressure: stall_m holds EX/MEM, flush_m loads a bubble (flush beats stall, reset beats both).
// Ports       : clk, rst_n (synchronous, active-low) plus the execute_stage_if slave bundle.
module execute_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  execute_stage_if.slave bus
);

  // ALU operation codes produced by the decoder
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  // forwarding mux selects
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // EX/MEM register state
  logic [XLEN-1:0]       alu_result_q;
  logic [XLEN-1:0]       write_data_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       pc_plus4_q;
  logic                  reg_write_q;
  logic                  mem_write_q;
  logic [1:0]            result_src_q;
  logic                  valid_q;

  // datapath
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_result;
  logic            cond_eq;
  logic            cond_lt;
  logic            cond_ltu;
  logic            cond;
  logic [XLEN-1:0] target_base;
  logic [XLEN-1:0] target_sum;

  // Operand forwarding. Code 11 is unused by the hazard unit and falls back to the register file.
  always_comb begin
    src_a = bus.rd1_e;
    case (bus.forward_a_e)
      FWD_WB:  src_a = bus.result_w;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = bus.rd1_e;
    endcase
  end

  always_comb begin
    fwd_b = bus.rd2_e;
    case (bus.forward_b_e)
      FWD_WB:  fwd_b = bus.result_w;
      FWD_MEM: fwd_b = alu_result_q;
      default: fwd_b = bus.rd2_e;
    endcase
  end

  assign src_b = bus.alu_src_e ? bus.imm_ext_e : fwd_b;
  assign shamt = src_b[4:0];

  // ALU; unassigned codes return zero so a bad decode cannot leak operand data.
  always_comb begin
    alu_result = '0;
    case (bus.alu_control_e)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
      default:  alu_result = '0;
    endcase
  end

  // Branch comparison uses the forwarded register operands, never the immediate.
  assign cond_eq  = (src_a == fwd_b);
  assign cond_lt  = ($signed(src_a) < $signed(fwd_b));
  assign cond_ltu = (src_a < fwd_b);

  always_comb begin
    cond = 1'b0;
    case (bus.funct3_e)
      3'b000:  cond = cond_eq;
      3'b001:  cond = ~cond_eq;
      3'b100:  cond = cond_lt;
      3'b101:  cond = ~cond_lt;
      3'b110:  cond = cond_ltu;
      3'b111:  cond = ~cond_ltu;
      default: cond = 1'b0;
    endcase
  end

  assign bus.pc_src_e = bus.valid_e & (bus.jump_e | (bus.branch_e & cond));

  // Target is produced every cycle; jalr clears bit 0 of the sum.
  assign target_base     = bus.jalr_e ? src_a : bus.pc_e;
  assign target_sum      = target_base + bus.imm_ext_e;
  assign bus.pc_target_e = bus.jalr_e ? {target_sum[XLEN-1:1], 1'b0} : target_sum;

  // EX/MEM register: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush_m) begin
      alu_result_q <= '0;
      write_data_q <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      valid_q      <= 1'b0;
    end else if (!bus.stall_m) begin
      alu_result_q <= alu_result;
      write_data_q <= fwd_b;
      rd_q         <= bus.rd_e;
      pc_plus4_q   <= bus.pc_plus4_e;
      // an invalid slot must not commit architectural state downstream
      reg_write_q  <= bus.reg_write_e & bus.valid_e;
      mem_write_q  <= bus.mem_write_e & bus.valid_e;
      result_src_q <= bus.result_src_e;
      valid_q      <= bus.valid_e;
    end
  end

  assign bus.alu_result_m = alu_result_q;
  assign bus.write_data_m = write_data_q;
  assign bus.rd_m         = rd_q;
  assign bus.pc_plus4_m   = pc_plus4_q;
  assign bus.reg_write_m  = reg_write_q;
  assign bus.mem_write_m  = mem_write_q;
  assign bus.result_src_m = result_src_q;
  assign bus.valid_m      = valid_q;

endmodule

// File: tb/tb_execute_stage.sv
// Purpose : self-checking bench for execute_stage - directed scenarios plus randomized traffic
//           compared against a behavioural model of the execute stage.
// Ports   : drives the execute_stage_if bundle, clk and rst_n; no ports of its own.
module tb_execute_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  execute_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();

  execute_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model of the EX/MEM register contents
  logic [31:0] m_alu = '0, m_wd = '0, m_pc4 = '0;
  logic [4:0]  m_rd = '0;
  logic [1:0]  m_rs = '0;
  logic        m_rw = 1'b0, m_mw = 1'b0, m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    longint sa, sb;
    logic [31:0] fill;
    s  = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      4'd0:  return a + b;
      4'd1:  return a + (~b + 32'd1);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a * (32'd1 << s);
      4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  return a ^ b;
      4'd7:  return a / (32'd1 << s);
      4'd8:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
      4'd15: begin
        fill = a[31] ? ~(32'hFFFF_FFFF / (32'd1 << s)) : 32'd0;
        return (a / (32'd1 << s)) | fill;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_idle();
    bus.stall_m = 0; bus.flush_m = 0; bus.valid_e = 1;
    bus.rd1_e = 0; bus.rd2_e = 0; bus.imm_ext_e = 0; bus.pc_e = 0; bus.pc_plus4_e = 0;
    bus.rd_e = 0; bus.alu_control_e = 0; bus.alu_src_e = 0; bus.funct3_e = 3'd2;
    bus.branch_e = 0; bus.jump_e = 0; bus.jalr_e = 0; bus.reg_write_e = 0;
    bus.mem_write_e = 0; bus.result_src_e = 0; bus.forward_a_e = 0; bus.forward_b_e = 0;
    bus.result_w = 0;
  endtask

  task automatic rand_inputs();
    bus.valid_e       = ($urandom_range(0, 7) != 0);
    bus.rd1_e         = $urandom;
    bus.rd2_e         = ($urandom_range(0, 3) == 0) ? bus.rd1_e : $urandom;
    bus.imm_ext_e     = $urandom;
    bus.pc_e          = $urandom & 32'hFFFF_FFFC;
    bus.pc_plus4_e    = bus.pc_e + 32'd4;
    bus.rd_e          = 5'($urandom_range(0, 31));
    bus.alu_control_e = 4'($urandom_range(0, 15));
    bus.alu_src_e     = 1'($urandom_range(0, 1));
    bus.funct3_e      = 3'($urandom_range(0, 7));
    bus.branch_e      = 1'($urandom_range(0, 1));
    bus.jump_e        = ($urandom_range(0, 3) == 0);
    bus.jalr_e        = 1'($urandom_range(0, 1));
    bus.reg_write_e   = 1'($urandom_range(0, 1));
    bus.mem_write_e   = 1'($urandom_range(0, 1));
    bus.result_src_e  = 2'($urandom_range(0, 3));
    bus.forward_a_e   = 2'($urandom_range(0, 3));
    bus.forward_b_e   = 2'($urandom_range(0, 3));
    bus.result_w      = $urandom;
  endtask

  // One clock: check combinational redirect, advance model across the edge, check EX/MEM.
  task automatic cycle(input bit chk_comb);
    logic [31:0] a, fb, sb, alu, tgt;
    bit take, do_rst, do_flush, do_stall;
    #1;
    a    = pick(bus.forward_a_e, bus.rd1_e, bus.result_w, m_alu);
    fb   = pick(bus.forward_b_e, bus.rd2_e, bus.result_w, m_alu);
    sb   = bus.alu_src_e ? bus.imm_ext_e : fb;
    alu  = ref_alu(bus.alu_control_e, a, sb);
    take = bus.valid_e && (bus.jump_e || (bus.branch_e && ref_cond(bus.funct3_e, a, fb)));
    tgt  = bus.jalr_e ? ((a + bus.imm_ext_e) & 32'hFFFF_FFFE) : (bus.pc_e + bus.imm_ext_e);
    if (chk_comb) begin
      check("pc_src_e", {31'd0, bus.pc_src_e}, {31'd0, take});
      check("pc_target_e", bus.pc_target_e, tgt);
    end
    do_rst   = !rst_n;
    do_flush = bus.flush_m;
    do_stall = bus.stall_m;
    @(posedge clk);
    if (do_rst || do_flush) begin
      m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_rs = 0; m_rw = 0; m_mw = 0; m_valid = 0;
    end else if (!do_stall) begin
      m_alu = alu; m_wd = fb; m_pc4 = bus.pc_plus4_e; m_rd = bus.rd_e; m_rs = bus.result_src_e;
      m_valid = bus.valid_e;
      m_rw = bus.valid_e && bus.reg_write_e;
      m_mw = bus.valid_e && bus.mem_write_e;
    end
    #1;
    check("alu_result_m", bus.alu_result_m, m_alu);
    check("write_data_m", bus.write_data_m, m_wd);
    check("pc_plus4_m", bus.pc_plus4_m, m_pc4);
    check("rd_m", {27'd0, bus.rd_m}, {27'd0, m_rd});
    check("result_src_m", {30'd0, bus.result_src_m}, {30'd0, m_rs});
    check("reg_write_m", {31'd0, bus.reg_write_m}, {31'd0, m_rw});
    check("mem_write_m", {31'd0, bus.mem_write_m}, {31'd0, m_mw});
    check("valid_m", {31'd0, bus.valid_m}, {31'd0, m_valid});
  endtask

  logic [3:0]  sweep_code [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF, 4'hA};
  logic [31:0] sweep_exp  [11] = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'h0, 32'hFFFF_FFF4, 32'hFFFF_FF00,
                                   32'h1, 32'hFFFF_FFF4, 32'h0FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};

  initial begin
    // reset held with a stall and a live instruction present
    set_idle();
    bus.rd1_e = 32'h55; bus.rd2_e = 32'h66; bus.reg_write_e = 1; bus.mem_write_e = 1;
    bus.rd_e = 5'd9; bus.pc_plus4_e = 32'h44; bus.stall_m = 1;
    rst_n = 0;
    cycle(0);
    check("rst_valid_m", {31'd0, bus.valid_m}, 32'd0);
    check("rst_alu_result_m", bus.alu_result_m, 32'd0);
    check("rst_reg_write_m", {31'd0, bus.reg_write_m}, 32'd0);
    cycle(1);
    rst_n = 1;
    set_idle();

    // ALU sweep
    bus.rd1_e = 32'hFFFF_FFF0; bus.rd2_e = 32'd4;
    for (int i = 0; i < 11; i++) begin
      bus.alu_control_e = sweep_code[i];
      cycle(1);
      check($sformatf("alu_sweep_%0h", sweep_code[i]), bus.alu_result_m, sweep_exp[i]);
    end

    // forwarding
    set_idle();
    bus.rd1_e = 32'h10;
    cycle(1);
    bus.rd1_e = 32'd1; bus.result_w = 32'h20; bus.imm_ext_e = 32'd5; bus.alu_src_e = 1;
    bus.forward_a_e = 2'b10;
    cycle(1);
    check("fwd_a_mem", bus.alu_result_m, 32'h15);
    bus.forward_a_e = 2'b01;
    cycle(1);
    check("fwd_a_wb", bus.alu_result_m, 32'h25);
    bus.forward_a_e = 2'b00; bus.forward_b_e = 2'b01; bus.rd2_e = 32'h99; bus.mem_write_e = 1;
    cycle(1);
    check("fwd_b_store", bus.write_data_m, 32'h20);
    check("store_mem_write", {31'd0, bus.mem_write_m}, 32'd1);

    // branches
    set_idle();
    bus.pc_e = 32'h100; bus.imm_ext_e = 32'h20; bus.branch_e = 1;
    bus.funct3_e = 3'd0; bus.rd1_e = 32'd7; bus.rd2_e = 32'd7;
    #1;
    check("beq_taken", {31'd0, bus.pc_src_e}, 32'd1);
    check("beq_target", bus.pc_target_e, 32'h120);
    cycle(1);
    bus.funct3_e = 3'd6; bus.rd1_e = 32'hFFFF_FFFF; bus.rd2_e = 32'd1;
    #1;
    check("bltu_not_taken", {31'd0, bus.pc_src_e}, 32'd0);
    cycle(1);
    bus.funct3_e = 3'd4;
    #1;
    check("blt_taken", {31'd0, bus.pc_src_e}, 32'd1);
    cycle(1);
    bus.valid_e = 0;
    #1;
    check("blt_invalid", {31'd0, bus.pc_src_e}, 32'd0);
    cycle(1);

    // jalr
    set_idle();
    bus.rd1_e = 32'h203; bus.imm_ext_e = 32'd4; bus.alu_src_e = 1; bus.jump_e = 1; bus.jalr_e = 1;
    bus.pc_e = 32'h1230; bus.pc_plus4_e = 32'h1234; bus.reg_write_e = 1;
    #1;
    check("jalr_taken", {31'd0, bus.pc_src_e}, 32'd1);
    check("jalr_target", bus.pc_target_e, 32'h206);
    cycle(1);
    check("jalr_pc_plus4_m", bus.pc_plus4_m, 32'h1234);

    // stall for three cycles with changing inputs
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      bus.stall_m = 1; bus.flush_m = 0;
      cycle(1);
      check("stall_pc_plus4_m", bus.pc_plus4_m, 32'h1234);
      check("stall_alu_result_m", bus.alu_result_m, 32'h207);
    end

    // stall and flush together
    bus.stall_m = 1; bus.flush_m = 1; bus.valid_e = 1; bus.reg_write_e = 1; bus.mem_write_e = 1;
    cycle(1);
    check("flush_valid_m", {31'd0, bus.valid_m}, 32'd0);
    check("flush_reg_write_m", {31'd0, bus.reg_write_m}, 32'd0);
    check("flush_mem_write_m", {31'd0, bus.mem_write_m}, 32'd0);
    check("flush_alu_result_m", bus.alu_result_m, 32'd0);

    // invalid slot loaded
    set_idle();
    bus.valid_e = 0; bus.reg_write_e = 1; bus.mem_write_e = 1; bus.rd_e = 5'd7;
    cycle(1);
    check("invalid_reg_write_m", {31'd0, bus.reg_write_m}, 32'd0);
    check("invalid_rd_m", {27'd0, bus.rd_m}, 32'd7);

    // reset arriving during a stall
    set_idle();
    bus.rd1_e = 32'h77; bus.reg_write_e = 1;
    cycle(1);
    bus.stall_m = 1;
    rst_n = 0;
    cycle(1);
    check("rst_stall_alu_result_m", bus.alu_result_m, 32'd0);
    check("rst_stall_valid_m", {31'd0, bus.valid_m}, 32'd0);
    rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      bus.stall_m = ($urandom_range(0, 4) == 0);
      bus.flush_m = ($urandom_range(0, 6) == 0);
      rst_n       = ($urandom_range(0, 49) != 0);
      cycle(1);
    end
    rst_n = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
